// File: rtl/sreg_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sreg_sched_ctrl
//  Purpose  : Schedule controller for a shift-register style buffer memory.
//             A start pulse launches one schedule of extent_x*extent_y writes
//             beginning at schedule cycle wr_start, and the same number of
//             reads beginning at rd_start. Addresses run linearly and wrap
//             modulo DEPTH.
//  Ports    : clk, rst_n       - clock (rising edge), async active-low reset
//             clk_en           - global stall, low freezes all state
//             start            - launch pulse, sampled in IDLE only
//             cfg_extent_x/y   - inner / outer loop extents
//             cfg_wr_start     - schedule cycle of the first write
//             cfg_rd_start     - schedule cycle of the first read
//             write_addr_0/wen_0, read_addr_0/ren_0 - memory port controls
//             busy, done, cfg_err - status
//  Revision : 1.0 - initial release
// ============================================================================
module sreg_sched_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [CTRL_WIDTH-1:0] cfg_extent_x,
  input  logic [CTRL_WIDTH-1:0] cfg_extent_y,
  input  logic [CTRL_WIDTH-1:0] cfg_wr_start,
  input  logic [CTRL_WIDTH-1:0] cfg_rd_start,
  output logic [CTRL_WIDTH-1:0] write_addr_0,
  output logic                  wen_0,
  output logic [CTRL_WIDTH-1:0] read_addr_0,
  output logic                  ren_0,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int CW = CTRL_WIDTH;
  localparam int PW = 2 * CTRL_WIDTH;
  localparam int LW = CTRL_WIDTH + 33;
  localparam logic [CW-1:0] C_ADDR_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_CYC_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured configuration
  logic [CW-1:0] r_ext_x, r_ext_y, r_wr_start, r_rd_start;
  logic [PW-1:0] r_total;

  // Schedule state
  logic [CW-1:0] r_cyc;
  logic [PW-1:0] r_wr_cnt, r_rd_cnt;     // accesses issued, including current cycle
  logic [CW-1:0] r_wr_ptr, r_rd_ptr;     // address of the next access
  logic [CW-1:0] r_wr_x, r_wr_y, r_rd_x, r_rd_y;
  logic [CW-1:0] r_waddr, r_raddr;
  logic          r_wen, r_ren, r_done, r_err;

  function automatic logic [CTRL_WIDTH-1:0] wrap_inc(input logic [CTRL_WIDTH-1:0] v,
                                                     input logic [CTRL_WIDTH-1:0] last);
    return (v == last) ? '0 : v + CTRL_WIDTH'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Start qualification. The lag is only meaningful when rd_start > wr_start,
  // which is checked first, so the subtraction never needs to wrap.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_lag;
  logic          w_cfg_bad, w_start_req, w_start_ok, w_start_bad;

  assign w_lag       = cfg_rd_start - cfg_wr_start;
  assign w_cfg_bad   = (cfg_extent_x == '0) || (cfg_extent_y == '0) ||
                       (cfg_rd_start <= cfg_wr_start) ||
                       (LW'(w_lag) > LW'(DEPTH));
  assign w_start_req = clk_en && start && (r_state == S_IDLE);
  assign w_start_ok  = w_start_req && !w_cfg_bad;
  assign w_start_bad = w_start_req && w_cfg_bad;

  // --------------------------------------------------------------------------
  // Effective values for the coming cycle: on an accepted start the fresh
  // configuration and zeroed counters are used directly, so an access at
  // schedule cycle 0 is issued in the very first RUN cycle.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_ext_x_e, w_ext_y_e, w_wr_start_e, w_rd_start_e;
  logic [PW-1:0] w_total_e, w_wr_cnt_e, w_rd_cnt_e;
  logic [CW-1:0] w_wr_ptr_e, w_rd_ptr_e, w_wr_x_e, w_wr_y_e, w_rd_x_e, w_rd_y_e;
  logic [CW-1:0] w_cyc_nxt;
  logic          w_last_read, w_wen_nxt, w_ren_nxt, w_run_nxt;

  assign w_ext_x_e    = w_start_ok ? cfg_extent_x : r_ext_x;
  assign w_ext_y_e    = w_start_ok ? cfg_extent_y : r_ext_y;
  assign w_wr_start_e = w_start_ok ? cfg_wr_start : r_wr_start;
  assign w_rd_start_e = w_start_ok ? cfg_rd_start : r_rd_start;
  assign w_total_e    = w_start_ok ? PW'(cfg_extent_x) * PW'(cfg_extent_y) : r_total;
  assign w_wr_cnt_e   = w_start_ok ? '0 : r_wr_cnt;
  assign w_rd_cnt_e   = w_start_ok ? '0 : r_rd_cnt;
  assign w_wr_ptr_e   = w_start_ok ? '0 : r_wr_ptr;
  assign w_rd_ptr_e   = w_start_ok ? '0 : r_rd_ptr;
  assign w_wr_x_e     = w_start_ok ? '0 : r_wr_x;
  assign w_wr_y_e     = w_start_ok ? '0 : r_wr_y;
  assign w_rd_x_e     = w_start_ok ? '0 : r_rd_x;
  assign w_rd_y_e     = w_start_ok ? '0 : r_rd_y;

  assign w_cyc_nxt = w_start_ok ? '0 :
                     (r_cyc == C_CYC_MAX) ? r_cyc : r_cyc + CW'(1);

  // The current cycle carries the final read of the schedule.
  assign w_last_read = (r_state == S_RUN) && r_ren && (r_rd_cnt == r_total);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last_read) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run_nxt = (w_state_nxt == S_RUN);
  assign w_wen_nxt = w_run_nxt && (w_cyc_nxt >= w_wr_start_e) && (w_wr_cnt_e < w_total_e);
  assign w_ren_nxt = w_run_nxt && (w_cyc_nxt >= w_rd_start_e) && (w_rd_cnt_e < w_total_e);

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_x    <= '0;
      r_ext_y    <= '0;
      r_wr_start <= '0;
      r_rd_start <= '0;
      r_total    <= '0;
      r_cyc      <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (clk_en) begin
      if (w_start_ok) begin
        r_ext_x    <= cfg_extent_x;
        r_ext_y    <= cfg_extent_y;
        r_wr_start <= cfg_wr_start;
        r_rd_start <= cfg_rd_start;
        r_total    <= w_total_e;
      end

      if (w_start_ok || (r_state == S_RUN)) begin
        r_cyc <= w_cyc_nxt;
      end

      if (w_start_bad) begin
        r_err <= 1'b1;
      end else if (w_start_ok) begin
        r_err <= 1'b0;
      end

      r_wen  <= w_wen_nxt;
      r_ren  <= w_ren_nxt;
      r_done <= (w_state_nxt == S_DONE);

      // Write port
      if (w_wen_nxt) begin
        r_wr_cnt <= w_wr_cnt_e + PW'(1);
        r_waddr  <= w_wr_ptr_e;
        r_wr_ptr <= wrap_inc(w_wr_ptr_e, C_ADDR_LAST);
        r_wr_x   <= wrap_inc(w_wr_x_e, w_ext_x_e - CW'(1));
        if (w_wr_x_e == w_ext_x_e - CW'(1)) begin
          r_wr_y <= wrap_inc(w_wr_y_e, w_ext_y_e - CW'(1));
        end else begin
          r_wr_y <= w_wr_y_e;
        end
      end else begin
        r_wr_cnt <= w_wr_cnt_e;
        r_wr_ptr <= w_wr_ptr_e;
        r_wr_x   <= w_wr_x_e;
        r_wr_y   <= w_wr_y_e;
        if (w_start_ok) r_waddr <= '0;
      end

      // Read port
      if (w_ren_nxt) begin
        r_rd_cnt <= w_rd_cnt_e + PW'(1);
        r_raddr  <= w_rd_ptr_e;
        r_rd_ptr <= wrap_inc(w_rd_ptr_e, C_ADDR_LAST);
        r_rd_x   <= wrap_inc(w_rd_x_e, w_ext_x_e - CW'(1));
        if (w_rd_x_e == w_ext_x_e - CW'(1)) begin
          r_rd_y <= wrap_inc(w_rd_y_e, w_ext_y_e - CW'(1));
        end else begin
          r_rd_y <= w_rd_y_e;
        end
      end else begin
        r_rd_cnt <= w_rd_cnt_e;
        r_rd_ptr <= w_rd_ptr_e;
        r_rd_x   <= w_rd_x_e;
        r_rd_y   <= w_rd_y_e;
        if (w_start_ok) r_raddr <= '0;
      end
    end
  end

  // Strobes come straight from flops; the stall qualifier only masks them so
  // the memory sees no access in a cycle where the schedule itself is frozen.
  // The pending access is re-presented once clk_en returns.
  assign wen_0        = r_wen & clk_en;
  assign ren_0        = r_ren & clk_en;
  assign done         = r_done & clk_en;
  assign write_addr_0 = r_waddr;
  assign read_addr_0  = r_raddr;
  assign busy         = (r_state != S_IDLE);
  assign cfg_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sreg_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sreg_sched_ctrl
//  Purpose  : Directed self-checking bench for sreg_sched_ctrl: reset state,
//             basic schedule, stall, config rejects, ignored start, abort by
//             reset, and a full-depth wrap schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sreg_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        start;
  logic [15:0] cfg_extent_x, cfg_extent_y, cfg_wr_start, cfg_rd_start;
  logic [15:0] write_addr_0, read_addr_0;
  logic        wen_0, ren_0, busy, done, cfg_err;

  int n_assert = 0;
  int n_fail   = 0;

  sreg_sched_ctrl #(.DEPTH(1024), .CTRL_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .start        (start),
    .cfg_extent_x (cfg_extent_x),
    .cfg_extent_y (cfg_extent_y),
    .cfg_wr_start (cfg_wr_start),
    .cfg_rd_start (cfg_rd_start),
    .write_addr_0 (write_addr_0),
    .wen_0        (wen_0),
    .read_addr_0  (read_addr_0),
    .ren_0        (ren_0),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wen"},   32'(wen_0),        0);
    chk({tag, " ren"},   32'(ren_0),        0);
    chk({tag, " waddr"}, 32'(write_addr_0), 0);
    chk({tag, " raddr"}, 32'(read_addr_0),  0);
    chk({tag, " busy"},  32'(busy),         0);
    chk({tag, " done"},  32'(done),         0);
    chk({tag, " err"},   32'(cfg_err),      0);
  endtask

  // Basic schedule x=4 y=2 wr=1 rd=6. Logical cycle v: writes on v=1..8 at
  // addresses 0..7, reads on v=6..13 at 0..7, done at v=14, idle at v=15.
  // Optional stall (clk_en low for stall_len cycles at v=stall_at), ignored
  // start pulse at v=ign_at, and reset abort at v=abort_at. Entered and left
  // 1 time unit after a rising edge.
  task automatic run_basic(input int stall_at, input int stall_len,
                           input int ign_at, input int abort_at);
    int v;
    bit stalled;
    cfg_extent_x = 16'd4; cfg_extent_y = 16'd2;
    cfg_wr_start = 16'd1; cfg_rd_start = 16'd6;
    clk_en = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Changes after acceptance must not matter.
    cfg_extent_x = 16'd1; cfg_extent_y = 16'd1;
    cfg_wr_start = 16'd0; cfg_rd_start = 16'd3;
    for (int k = 0; k < 16 + stall_len; k++) begin
      stalled = (stall_at >= 0) && (k >= stall_at) && (k < stall_at + stall_len);
      if (stalled) v = stall_at;
      else if ((stall_at >= 0) && (k >= stall_at + stall_len)) v = k - stall_len;
      else v = k;
      clk_en = !stalled;
      start  = (v == ign_at) && !stalled;
      #1;
      chk($sformatf("basic wen v=%0d k=%0d", v, k), 32'(wen_0),
          (!stalled && v >= 1 && v <= 8) ? 1 : 0);
      chk($sformatf("basic waddr v=%0d k=%0d", v, k), 32'(write_addr_0),
          (v < 1) ? 0 : (v > 8) ? 7 : v - 1);
      chk($sformatf("basic ren v=%0d k=%0d", v, k), 32'(ren_0),
          (!stalled && v >= 6 && v <= 13) ? 1 : 0);
      chk($sformatf("basic raddr v=%0d k=%0d", v, k), 32'(read_addr_0),
          (v < 6) ? 0 : (v > 13) ? 7 : v - 6);
      chk($sformatf("basic done v=%0d k=%0d", v, k), 32'(done),
          (!stalled && v == 14) ? 1 : 0);
      chk($sformatf("basic busy v=%0d k=%0d", v, k), 32'(busy), (v <= 14) ? 1 : 0);
      chk($sformatf("basic err v=%0d k=%0d", v, k), 32'(cfg_err), 0);
      if (v == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_quiet("abort async");
        @(posedge clk); #1;
        chk_quiet("abort held");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort after wen", 32'(wen_0), 0);
          chk("abort after ren", 32'(ren_0), 0);
          chk("abort after busy", 32'(busy), 0);
        end
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    clk_en = 1'b1;
  endtask

  task automatic cfg_reject(input logic [15:0] ex, input logic [15:0] ey,
                            input logic [15:0] ws, input logic [15:0] rs,
                            input string tag);
    cfg_extent_x = ex; cfg_extent_y = ey;
    cfg_wr_start = ws; cfg_rd_start = rs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk({tag, " err"},  32'(cfg_err), 1);
    chk({tag, " busy"}, 32'(busy),    0);
    repeat (3) begin
      chk({tag, " wen"}, 32'(wen_0), 0);
      chk({tag, " ren"}, 32'(ren_0), 0);
      @(posedge clk); #1;
    end
    chk({tag, " busy later"}, 32'(busy), 0);
  endtask

  // Full-depth schedule: 1280 accesses, read lag exactly DEPTH.
  task automatic run_wrap();
    int occ, peak, nrd;
    occ = 0; peak = 0; nrd = 0;
    cfg_extent_x = 16'd64;  cfg_extent_y = 16'd20;
    cfg_wr_start = 16'd0;   cfg_rd_start = 16'd1024;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int v = 0; v < 2306; v++) begin
      #1;
      chk($sformatf("wrap wen v=%0d", v), 32'(wen_0), (v < 1280) ? 1 : 0);
      chk($sformatf("wrap waddr v=%0d", v), 32'(write_addr_0),
          ((v < 1280) ? v : 1279) % 1024);
      chk($sformatf("wrap ren v=%0d", v), 32'(ren_0),
          (v >= 1024 && v < 2304) ? 1 : 0);
      chk($sformatf("wrap raddr v=%0d", v), 32'(read_addr_0),
          (v < 1024) ? 0 : (((v < 2304) ? v - 1024 : 1279) % 1024));
      chk($sformatf("wrap done v=%0d", v), 32'(done), (v == 2304) ? 1 : 0);
      occ = occ + int'(wen_0) - int'(ren_0);
      nrd = nrd + int'(ren_0);
      if (occ > peak) peak = occ;
      chk($sformatf("wrap occupancy in range v=%0d occ=%0d", v, occ),
          32'((occ >= 0) && (occ <= 1024)), 1);
      @(posedge clk); #1;
    end
    chk("wrap peak occupancy", 32'(peak), 1024);
    chk("wrap read count", 32'(nrd), 1280);
    chk("wrap final raddr", 32'(read_addr_0), 255);
    chk("wrap idle", 32'(busy), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    cfg_extent_x = '0; cfg_extent_y = '0;
    cfg_wr_start = '0; cfg_rd_start = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("post reset idle");

    run_basic(-1, 0, -1, -1);          // basic run
    run_basic(7, 3, -1, -1);           // stall at cyc 7 for 3 cycles

    cfg_reject(16'd4, 16'd2, 16'd5, 16'd5,    "reject lag0");
    cfg_reject(16'd4, 16'd2, 16'd0, 16'd1025, "reject lag1025");
    cfg_reject(16'd0, 16'd2, 16'd1, 16'd6,    "reject x0");
    run_basic(-1, 0, -1, -1);          // valid start clears cfg_err

    run_basic(-1, 0, 3, 4);            // ignored start at cyc 3, reset at cyc 4
    run_basic(-1, 0, -1, -1);          // fresh launch reproduces basic run

    run_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sreg_sched_ctrl.md
SREG_SCHED_CTRL -- requirements
Module: sreg_sched_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory word count; address wraps modulo DEPTH.
REQ-002 SHALL have parameter CTRL_WIDTH, default 16, width of addresses, extents and schedule counters.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global stall; low freezes all state.
- start  in  1  single-cycle pulse that launches one schedule.
- cfg_extent_x  in  CTRL_WIDTH  inner loop extent.
- cfg_extent_y  in  CTRL_WIDTH  outer loop extent.
- cfg_wr_start  in  CTRL_WIDTH  schedule cycle of first write.
- cfg_rd_start  in  CTRL_WIDTH  schedule cycle of first read.
- write_addr_0  out  CTRL_WIDTH  memory write address.
- wen_0  out  1  memory write enable.
- read_addr_0  out  CTRL_WIDTH  memory read address.
- ren_0  out  1  memory read enable.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  sticky: last start rejected.

Function
REQ-004 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-005 SHALL capture all cfg_* inputs on the accepted start edge; cfg changes during RUN have no effect.
REQ-006 Start is accepted only in IDLE with clk_en=1; start in RUN/DONE is ignored.
REQ-007 SHALL reject a start (stay IDLE, set cfg_err) if:
- either extent is 0; or
- lag = cfg_rd_start - cfg_wr_start is < 1 or > DEPTH (unsigned compare, no wrap).
REQ-008 On an accepted start SHALL clear cfg_err and enter RUN with schedule counter cyc=0 in the first RUN cycle.
REQ-009 In RUN with clk_en=1, cyc SHALL increment by 1 per cycle; it saturates at all-ones.
REQ-010 Write phase:
- wen_0=1 on cycles where cyc >= wr_start and writes issued < extent_x*extent_y.
- Product SHALL be computed at 2*CTRL_WIDTH bits.
REQ-011 Read phase: same rule as REQ-010 using rd_start and the read count.
REQ-012 Addressing:
- write_addr_0 starts at 0 and increments by 1 after each write, wrapping DEPTH-1 -> 0.
- read_addr_0 follows the same rule.
- Each port SHALL also track x/y counters (x wraps at extent_x, incrementing y).
REQ-013 wen_0, ren_0 and both addresses SHALL be registered outputs.
REQ-014 Addresses hold their last value when the enable is 0.
REQ-015 Simultaneous read and write in one cycle SHALL be allowed, including the same address; ordering is owned by the memory.
REQ-016 RUN -> DONE in the cycle after the final read; done=1 for exactly that DONE cycle, then IDLE.
REQ-017 busy=1 in RUN and DONE, 0 in IDLE.
REQ-018 clk_en=0:
- wen_0=0, ren_0=0, done=0.
- All counters, addresses and FSM state hold.
- Operation resumes exactly where it stopped when clk_en returns to 1.
REQ-019 Occupancy (writes issued minus reads issued) SHALL never exceed DEPTH or go negative; REQ-007 guarantees this, and the bench asserts it.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- FSM to IDLE, cyc and all counters to 0.
- write_addr_0=0, read_addr_0=0.
- wen_0=0, ren_0=0, busy=0, done=0, cfg_err=0.
REQ-021 Reset mid-RUN SHALL abort the schedule with no further wen_0/ren_0 pulses.
REQ-022 The first start after reset deassertion SHALL behave as a fresh launch.

Verification
REQ-023 Basic run: extent_x=4, extent_y=2, wr_start=1, rd_start=6, start pulse ->
- wen_0 on cyc 1..8 with write_addr_0 0..7.
- ren_0 on cyc 6..13 with read_addr_0 0..7.
- done on cyc 14, busy low on cyc 15.
REQ-024 Wrap: DEPTH=1024, extent_x=64, extent_y=20, wr_start=0, rd_start=1024 ->
- write_addr_0 goes 1023 -> 0 at write 1025.
- peak occupancy exactly 1024.
- 1280 reads, read_addr_0 ending at 255.
REQ-025 Config error, each case -> no wen_0/ren_0, cfg_err=1, busy=0:
- rd_start=wr_start=5;
- lag=1025;
- extent_x=0.
A following valid start clears cfg_err.
REQ-026 Stall: the REQ-023 config with clk_en low for 3 cycles at cyc=7 ->
- enables are 0 while clk_en is low;
- address/enable sequence otherwise identical, done delayed by 3 cycles.
REQ-027 Abort and ignored start:
- start pulsed during RUN is ignored;
- rst_n asserted at cyc=4 of REQ-023 -> all outputs 0 asynchronously;
- the next start reproduces REQ-023 exactly.
